// File: rtl/append_unpacker.sv
// Receive-side tag stripper: collects tagged 2-bit symbols, packs them MSB-first
// into output words, and drops the remainder of any frame carrying an illegal tag.
module append_unpacker #(
    parameter int N_SYM = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_word,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*N_SYM-1:0]       out_data,
    output logic                     out_last,
    output logic [$clog2(N_SYM):0]   out_cnt,
    output logic                     err_pulse,
    output logic [CNT_W-1:0]         err_count
);

    localparam int DW = 2 * N_SYM;
    localparam int CW = $clog2(N_SYM) + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DROP    = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   idx_p0, idx_d;
    logic [DW-1:0]   acc_p0, acc_d, acc_ins;
    logic [1:0]      tag, sym;
    logic            accept, load, err_set;

    function automatic logic [DW-1:0] place_sym(input logic [DW-1:0] acc,
                                                input logic [CW-1:0] idx,
                                                input logic [1:0]    s);
        logic [DW-1:0] r;
        r = acc;
        for (int p = 0; p < N_SYM; p++) begin
            if (idx == CW'(p)) r[DW-1-2*p -: 2] = s;
        end
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    assign tag = in_word[3:2];
    assign sym = in_word[1:0];

    // Held low during reset so nothing is taken while the collector is cleared.
    assign in_ready = rst_n && ((state_q == DROP) || !out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign acc_ins  = place_sym(acc_p0, idx_p0, sym);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_p0;
        acc_d   = acc_p0;
        load    = 1'b0;
        err_set = 1'b0;
        if (accept) begin
            case (state_q)
                IDLE, COLLECT: begin
                    if (!tag[1]) begin
                        err_set = 1'b1;
                        idx_d   = '0;
                        acc_d   = '0;
                        state_d = (state_q == COLLECT) ? DROP : IDLE;
                    end else if (idx_p0 == CW'(N_SYM - 1) || tag[0]) begin
                        load    = 1'b1;
                        idx_d   = '0;
                        acc_d   = '0;
                        state_d = IDLE;
                    end else begin
                        acc_d   = acc_ins;
                        idx_d   = idx_p0 + 1'b1;
                        state_d = COLLECT;
                    end
                end
                DROP: begin
                    if (tag == 2'b11) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Collector state and output register; load cannot collide with a stalled word
    // because in_ready already excludes that case outside DROP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_p0    <= '0;
            acc_p0    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_cnt   <= '0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            state_q   <= state_d;
            idx_p0    <= idx_d;
            acc_p0    <= acc_d;
            err_pulse <= err_set;
            if (err_set) err_count <= sat_inc(err_count);
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= acc_ins;
                out_cnt   <= idx_p0 + 1'b1;
                out_last  <= tag[0];
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/append_unpacker.md
Name: append_unpacker

Overview:
- Receive-side counterpart of the 2-bit tag-prepend blocks (append10/append11).
- Accepts a stream of 4-bit tagged words {tag[1:0], sym[1:0]}:
  - tag 2'b10: data symbol, frame continues.
  - tag 2'b11: data symbol, last of frame.
  - tags 2'b00 and 2'b01: illegal.
- Strips tags, packs N_SYM 2-bit symbols MSB-first into one output word, and emits it on a valid/ready interface.
- Illegal tags cause the rest of the frame to be dropped, and the drop is counted.

Parameters:
- N_SYM, 4: symbols packed per output word; legal range 2..8.
- CNT_W, 8: width of the saturating frame-error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block accepts in_word this cycle.
- in_word  input  4  {tag[1:0], sym[1:0]}.
- out_valid  output  1  out_data, out_last and out_cnt are valid.
- out_ready  input  1  downstream accepts the output word.
- out_data  output  2*N_SYM  packed symbols; first-received symbol in the MSBs.
- out_last  output  1  word closes a frame (tag 11 seen).
- out_cnt  output  $clog2(N_SYM)+1  number of valid symbols in out_data, 1..N_SYM.
- err_pulse  output  1  one-cycle pulse when an illegal tag is accepted.
- err_count  output  CNT_W  saturating count of illegal-tag events.

Behaviour:
- Reset (asynchronous, rst_n=0): all outputs 0, state IDLE, partial accumulator and symbol index cleared. A reset mid-frame discards the partial word and any pending output; after release the first accepted word starts a new frame.
- Acceptance: a word is accepted when in_valid && in_ready.
  - In IDLE/COLLECT: in_ready = !out_valid || out_ready.
  - In DROP: in_ready = 1 (discarding never needs output space).
- FSM states: IDLE (no partial symbols), COLLECT (1..N_SYM-1 symbols held), DROP (discarding the remainder of a bad frame).
- Legal word accepted in IDLE/COLLECT:
  - sym is stored at position idx; the MSB pair is position 0.
  - idx increments.
  - If idx reaches N_SYM, or tag==11: out_data, out_cnt=idx+1 and out_last=(tag==11) are registered, out_valid=1 on the next cycle, idx clears, and the state goes to IDLE.
  - Otherwise the state goes to COLLECT.
- Short final word: unused LSB symbol positions are 0. Example, N_SYM=4 with 3 symbols: out_data = {s0,s1,s2,2'b00}, out_cnt=3.
- Latency: accepting the completing word leads to out_valid on the following rising edge (1 cycle).
- Output register:
  - out_valid holds, with out_data, out_last and out_cnt stable, until out_valid && out_ready.
  - It clears on that handshake unless a new completion loads in the same cycle, in which case it stays 1 with the new data.
- Back-pressure: a stalled output (out_valid && !out_ready) drops in_ready only in IDLE/COLLECT. No input word is lost or duplicated.
- Illegal tag accepted in IDLE or COLLECT:
  - err_pulse=1 for the next cycle.
  - err_count increments, saturating at 2^CNT_W-1.
  - Partial symbols are discarded and nothing is emitted for the frame.
  - Next state: DROP if the illegal word arrived mid-frame (COLLECT); IDLE if it arrived in IDLE.
- DROP: every accepted word is discarded, and further illegal tags in DROP are not counted. A tag-11 word returns the state to IDLE; a tag-10 word stays in DROP.
- Simultaneous events: an output handshake and a new completion in the same cycle are both honoured. An illegal tag while out_valid is pending does not disturb the pending output word.
- Throughput: one input word per cycle when the output is not stalled.

Test Plan:
- Full word (N_SYM=4): in_word 0x8 (tag 10, sym 00), 0x9, 0xA, 0xF (tag 11, sym 11) -> out_data=8'h1B, out_cnt=4, out_last=1, one cycle after the 4th accept.
- Multi-word frame: 0xB,0xB,0xB,0xB,0xA,0xE (syms 11,11,11,11,10,10) -> word1 out_data=8'hFF out_cnt=4 out_last=0; word2 out_data=8'hA0 out_cnt=2 out_last=1.
- Back-pressure: hold out_ready=0 after word1 completes -> out_valid stays 1 and out_data stays stable, in_ready=0. Raising out_ready -> exactly one handshake and no lost input.
- Illegal tag mid-frame: 0x9, 0x5 (tag 01), 0xA, 0xC -> err_pulse one cycle, err_count=1, no output for that frame. Next frame 0xF -> out_data=8'hC0 out_cnt=1 out_last=1.
- Saturation: CNT_W=2, five separate illegal single-word frames -> err_count holds at 3 and err_pulse fires five times.
- Reset mid-frame: accept 0x9, 0xA, then assert rst_n=0 asynchronously -> all outputs 0 immediately. After release, 0xF -> out_data=8'hC0, out_cnt=1.
